// File: rtl/mult18_share_arb.sv
// mult18_share_arb: round-robin sharing of one registered 18x18 signed
// multiplier among NREQ requesters, with a credit-protected result FIFO.
//
// Ports:
//   C          clock, all state on rising edge
//   RN         asynchronous active-low reset
//   REQ        per-requester request, held until granted
//   A_IN/B_IN  signed 18-bit operands, slice i belongs to requester i
//   GNT        one-hot grant, operands sampled in the grant cycle
//   MA/MB      multiplier operands
//   MCE/MR     multiplier clock enable / synchronous reset
//   MP         multiplier registered 36-bit product
//   P_OUT      head-of-FIFO product
//   ID_OUT     requester that owns P_OUT
//   VALID_OUT  P_OUT/ID_OUT valid (FIFO non-empty)
//   RDY_OUT    consumer accepts the head entry when high with VALID_OUT
//   BUSY       product in flight or FIFO non-empty
module mult18_share_arb #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 4,
    parameter int IDW   = 2
) (
    input  logic                 C,
    input  logic                 RN,
    input  logic [NREQ-1:0]      REQ,
    input  logic [18*NREQ-1:0]   A_IN,
    input  logic [18*NREQ-1:0]   B_IN,
    output logic [NREQ-1:0]      GNT,
    output logic [17:0]          MA,
    output logic [17:0]          MB,
    output logic                 MCE,
    output logic                 MR,
    input  logic [35:0]          MP,
    output logic [35:0]          P_OUT,
    output logic [IDW-1:0]       ID_OUT,
    output logic                 VALID_OUT,
    input  logic                 RDY_OUT,
    output logic                 BUSY
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t state, state_nx;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] inflight_id;
    logic           inflight;

    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] scan_idx;
    logic           gnt_any;
    logic           issue_ok;
    logic           in_run;
    logic [AW+1:0]  cnt;

    logic [35:0]    mem_p  [DEPTH];
    logic [IDW-1:0] mem_id [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           push;
    logic           pop;
    logic           empty;
    logic           full;

    // ------------------------------------------------------------------
    // Sequencer: one INIT cycle clears the multiplier register, then RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state <= S_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        MR       = 1'b0;
        in_run   = 1'b0;
        unique case (state)
            S_INIT: begin
                MR       = 1'b1;
                state_nx = S_RUN;
            end
            S_RUN: begin
                in_run = 1'b1;
            end
            default: begin
                state_nx = S_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Credit: every FIFO slot is either occupied or reserved by the
    // product in flight. A pop in this cycle is deliberately not counted.
    // ------------------------------------------------------------------
    assign cnt      = {1'b0, count} + (AW+2)'(inflight);
    assign issue_ok = in_run && (cnt < (AW+2)'(DEPTH));

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan upward from the last winner plus one.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_any  = 1'b0;
        gnt_id   = '0;
        scan_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = IDW'((int'(ptr) + k) % NREQ);
            if (issue_ok && !gnt_any && REQ[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_id  = scan_idx;
            end
        end
    end

    always_comb begin
        GNT = '0;
        MA  = '0;
        MB  = '0;
        MCE = gnt_any;
        if (gnt_any) begin
            GNT[gnt_id] = 1'b1;
            MA          = A_IN[int'(gnt_id)*18 +: 18];
            MB          = B_IN[int'(gnt_id)*18 +: 18];
        end
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            ptr         <= IDW'(NREQ-1);
            inflight    <= 1'b0;
            inflight_id <= '0;
        end else begin
            inflight <= gnt_any;
            if (gnt_any) begin
                ptr         <= gnt_id;
                inflight_id <= gnt_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO (show-ahead). MP is valid the cycle after the grant,
    // which is exactly when the in-flight flag is set.
    // ------------------------------------------------------------------
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign push  = inflight;
    assign pop   = !empty && RDY_OUT;

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge C) begin
        if (push) begin
            mem_p[wr_ptr]  <= MP;
            mem_id[wr_ptr] <= inflight_id;
        end
    end

    assign VALID_OUT = !empty;
    assign P_OUT     = empty ? '0 : mem_p[rd_ptr];
    assign ID_OUT    = empty ? '0 : mem_id[rd_ptr];
    assign BUSY      = inflight | !empty;

    push_when_full: assert property (
        @(posedge C) disable iff (!RN) !(push && full)
    );

endmodule
